ir_nec_decoder: RTL and testbench

//  Decodes the demodulated IR receiver output (NEC protocol) into 32-bit frame codes.

---
 rtl/ir_nec_pkg.sv | 37 +++
 rtl/ir_nec_decoder_if.sv | 20 ++
 rtl/ir_sync_edge.sv | 29 ++
 rtl/ir_nec_decoder.sv | 190 +++++++++++++++++++
 tb/tb_ir_nec_decoder.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/ir_nec_pkg.sv
// Shared types and timing constants for the NEC IR decoder.
// All window limits are in microseconds and inclusive at both ends.
package ir_nec_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEAD_MARK,
        S_LEAD_SPACE,
        S_BIT_MARK,
        S_BIT_SPACE,
        S_STOP_MARK,
        S_RPT_STOP
    } state_t;

    localparam int CNT_W          = 16;
    localparam int TIMEOUT_US_DEF = 12000;

    localparam int LEAD_MARK_MIN_US  = 8000;
    localparam int LEAD_MARK_MAX_US  = 10000;
    localparam int LEAD_DATA_MIN_US  = 4000;
    localparam int LEAD_DATA_MAX_US  = 5000;
    localparam int LEAD_RPT_MIN_US   = 1800;
    localparam int LEAD_RPT_MAX_US   = 2700;
    localparam int BIT_MARK_MIN_US   = 400;
    localparam int BIT_MARK_MAX_US   = 750;
    localparam int SPACE0_MIN_US     = 400;
    localparam int SPACE0_MAX_US     = 750;
    localparam int SPACE1_MIN_US     = 1400;
    localparam int SPACE1_MAX_US     = 1950;

    function automatic logic in_win(input logic [CNT_W-1:0] w,
                                    input logic [CNT_W-1:0] lo,
                                    input logic [CNT_W-1:0] hi);
        return (w >= lo) && (w <= hi);
    endfunction

endpackage

// File: rtl/ir_nec_decoder_if.sv
// Receiver-line input and decoded-frame outputs of the NEC decoder.
// master = decoder side, slave = line driver / PIO consumer side.
interface ir_nec_decoder_if;
    logic        ir_rx;
    logic [31:0] code;
    logic        code_valid;
    logic        is_repeat;
    logic        frame_toggle;
    logic        frame_err;

    modport master (
        input  ir_rx,
        output code, code_valid, is_repeat, frame_toggle, frame_err
    );

    modport slave (
        output ir_rx,
        input  code, code_valid, is_repeat, frame_toggle, frame_err
    );
endinterface

// File: rtl/ir_sync_edge.sv
// Two-flop synchronizer for the raw IR line with registered fall/rise pulses.
// Flops reset to 1 so an idle (high) line produces no edge after reset.
module ir_sync_edge (
    input  logic clk,
    input  logic reset_n,
    input  logic i_rx,
    output logic o_fall,
    output logic o_rise
);
    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
            r_prev <= 1'b1;
            o_fall <= 1'b0;
            o_rise <= 1'b0;
        end else begin
            r_meta <= i_rx;
            r_sync <= r_meta;
            r_prev <= r_sync;
            o_fall <= r_prev & ~r_sync;
            o_rise <= ~r_prev & r_sync;
        end
    end
endmodule

// File: rtl/ir_nec_decoder.sv
// NEC IR frame decoder: measures mark/space widths and assembles 32-bit codes.
// Define IR_NEC_CHECK_EN to reject frames whose command byte fails its inverse check.
module ir_nec_decoder
    import ir_nec_pkg::*;
#(
    parameter int CLKS_PER_US = 50,
    parameter int TIMEOUT_US  = TIMEOUT_US_DEF,
    // Each width tick represents 2**TICK_SHIFT microseconds (0 = 1 us).
    parameter int TICK_SHIFT  = 0
) (
    input logic              clk,
    input logic              reset_n,
    ir_nec_decoder_if.master bus
);
    localparam int PS_W = (CLKS_PER_US > 1) ? $clog2(CLKS_PER_US) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(CLKS_PER_US - 1);

    localparam logic [CNT_W-1:0] W_TO    = CNT_W'(TIMEOUT_US       >> TICK_SHIFT);
    localparam logic [CNT_W-1:0] LM_LO   = CNT_W'(LEAD_MARK_MIN_US >> TICK_SHIFT);
    localparam logic [CNT_W-1:0] LM_HI   = CNT_W'(LEAD_MARK_MAX_US >> TICK_SHIFT);
    localparam logic [CNT_W-1:0] LD_LO   = CNT_W'(LEAD_DATA_MIN_US >> TICK_SHIFT);
    localparam logic [CNT_W-1:0] LD_HI   = CNT_W'(LEAD_DATA_MAX_US >> TICK_SHIFT);
    localparam logic [CNT_W-1:0] LR_LO   = CNT_W'(LEAD_RPT_MIN_US  >> TICK_SHIFT);
    localparam logic [CNT_W-1:0] LR_HI   = CNT_W'(LEAD_RPT_MAX_US  >> TICK_SHIFT);
    localparam logic [CNT_W-1:0] BM_LO   = CNT_W'(BIT_MARK_MIN_US  >> TICK_SHIFT);
    localparam logic [CNT_W-1:0] BM_HI   = CNT_W'(BIT_MARK_MAX_US  >> TICK_SHIFT);
    localparam logic [CNT_W-1:0] S0_LO   = CNT_W'(SPACE0_MIN_US    >> TICK_SHIFT);
    localparam logic [CNT_W-1:0] S0_HI   = CNT_W'(SPACE0_MAX_US    >> TICK_SHIFT);
    localparam logic [CNT_W-1:0] S1_LO   = CNT_W'(SPACE1_MIN_US    >> TICK_SHIFT);
    localparam logic [CNT_W-1:0] S1_HI   = CNT_W'(SPACE1_MAX_US    >> TICK_SHIFT);

    logic            w_fall;
    logic            w_rise;
    logic            w_edge;
    logic            w_tick;
    logic            w_timeout;
    logic            w_chk_ok;

    logic [PS_W-1:0]  r_ps;
    logic [CNT_W-1:0] r_cnt;
    state_t           r_state;
    logic [31:0]      r_sr;
    logic [4:0]       r_bitcnt;
    logic [31:0]      r_code;
    logic             r_valid;
    logic             r_rpt;
    logic             r_tog;
    logic             r_err;

    ir_sync_edge u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .i_rx    (bus.ir_rx),
        .o_fall  (w_fall),
        .o_rise  (w_rise)
    );

    assign w_edge    = w_fall | w_rise;
    assign w_tick    = (r_ps == PS_LAST);
    assign w_timeout = (r_cnt == W_TO);

`ifdef IR_NEC_CHECK_EN
    assign w_chk_ok = (r_sr[31:24] == ~r_sr[23:16]);
`else
    assign w_chk_ok = 1'b1;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ps  <= '0;
            r_cnt <= '0;
        end else begin
            r_ps <= w_tick ? '0 : r_ps + 1'b1;
            // An edge restarts the measurement and swallows a coincident tick.
            if (w_edge)
                r_cnt <= '0;
            else if (w_tick && !w_timeout)
                r_cnt <= r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_sr     <= '0;
            r_bitcnt <= '0;
            r_code   <= '0;
            r_valid  <= 1'b0;
            r_rpt    <= 1'b0;
            r_tog    <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            if (r_state != S_IDLE && !w_edge && w_timeout) begin
                r_state <= S_IDLE;
                r_err   <= 1'b1;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_fall)
                            r_state <= S_LEAD_MARK;
                    end
                    S_LEAD_MARK: begin
                        if (w_rise) begin
                            if (in_win(r_cnt, LM_LO, LM_HI)) begin
                                r_state <= S_LEAD_SPACE;
                            end else begin
                                r_state <= S_IDLE;
                                r_err   <= 1'b1;
                            end
                        end
                    end
                    S_LEAD_SPACE: begin
                        if (w_fall) begin
                            if (in_win(r_cnt, LD_LO, LD_HI)) begin
                                r_state  <= S_BIT_MARK;
                                r_bitcnt <= '0;
                            end else if (in_win(r_cnt, LR_LO, LR_HI)) begin
                                r_state <= S_RPT_STOP;
                            end else begin
                                r_state <= S_IDLE;
                                r_err   <= 1'b1;
                            end
                        end
                    end
                    S_BIT_MARK: begin
                        if (w_rise) begin
                            if (in_win(r_cnt, BM_LO, BM_HI)) begin
                                r_state <= S_BIT_SPACE;
                            end else begin
                                r_state <= S_IDLE;
                                r_err   <= 1'b1;
                            end
                        end
                    end
                    S_BIT_SPACE: begin
                        if (w_fall) begin
                            if (in_win(r_cnt, S0_LO, S0_HI) || in_win(r_cnt, S1_LO, S1_HI)) begin
                                // LSB-first on air: new bit enters at the top.
                                r_sr <= {in_win(r_cnt, S1_LO, S1_HI), r_sr[31:1]};
                                if (r_bitcnt == 5'd31) begin
                                    r_state <= S_STOP_MARK;
                                end else begin
                                    r_bitcnt <= r_bitcnt + 5'd1;
                                    r_state  <= S_BIT_MARK;
                                end
                            end else begin
                                r_state <= S_IDLE;
                                r_err   <= 1'b1;
                            end
                        end
                    end
                    S_STOP_MARK: begin
                        if (w_rise) begin
                            r_state <= S_IDLE;
                            if (in_win(r_cnt, BM_LO, BM_HI) && w_chk_ok) begin
                                r_code  <= r_sr;
                                r_rpt   <= 1'b0;
                                r_valid <= 1'b1;
                                r_tog   <= ~r_tog;
                            end else begin
                                r_err <= 1'b1;
                            end
                        end
                    end
                    S_RPT_STOP: begin
                        if (w_rise) begin
                            r_state <= S_IDLE;
                            if (in_win(r_cnt, BM_LO, BM_HI)) begin
                                r_rpt   <= 1'b1;
                                r_valid <= 1'b1;
                                r_tog   <= ~r_tog;
                            end else begin
                                r_err <= 1'b1;
                            end
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.code         = r_code;
    assign bus.code_valid   = r_valid;
    assign bus.is_repeat    = r_rpt;
    assign bus.frame_toggle = r_tog;
    assign bus.frame_err    = r_err;
endmodule

// File: tb/tb_ir_nec_decoder.sv
// Bench for ir_nec_decoder: IR waveforms built from microsecond durations, run with one
// width tick per clock at 16 us per tick so full frames stay short.
module tb_ir_nec_decoder;
    localparam int US_PER_CYC = 16;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    ir_nec_decoder_if bif();

    ir_nec_decoder #(
        .CLKS_PER_US (1),
        .TIMEOUT_US  (12000),
        .TICK_SHIFT  (4)
    ) u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bif)
    );

    int total = 0;
    int bad   = 0;
    int n_valid = 0;
    int n_err   = 0;

    logic [31:0] m_code;
    logic        m_rpt;
    logic        m_tog;

    typedef struct {
        logic [31:0] code;
        bit          rpt;
        int          bad_bit;
        bit          exp_v;
        bit          exp_e;
        logic [31:0] exp_code;
        bit          exp_r;
    } vec_t;

    vec_t tbl[5];

    always @(negedge clk) begin
        if (reset_n && bif.code_valid) n_valid++;
        if (reset_n && bif.frame_err)  n_err++;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic hold(input logic lvl, input int us);
        bif.ir_rx = lvl;
        repeat (us / US_PER_CYC) @(negedge clk);
    endtask

    function automatic int jit(input int nom, input int spread, input bit en);
        return en ? nom - spread + int'($urandom_range(2 * spread)) : nom;
    endfunction

    function automatic bit cmd_ok(input logic [31:0] c);
`ifdef IR_NEC_CHECK_EN
        return c[31:24] == ~c[23:16];
`else
        return 1'b1;
`endif
    endfunction

    // Full frame, repeat frame, or a frame cut short after a 1000 us space at bad_bit.
    task automatic send_frame(input logic [31:0] c, input bit rpt, input int bad_bit, input bit j);
        hold(1'b0, jit(9000, 500, j));
        if (rpt) begin
            hold(1'b1, jit(2250, 200, j));
            hold(1'b0, jit(562, 100, j));
            hold(1'b1, 400);
        end else begin
            hold(1'b1, jit(4500, 250, j));
            for (int i = 0; i < 32; i++) begin
                hold(1'b0, jit(562, 100, j));
                if (i == bad_bit) begin
                    hold(1'b1, 1000);
                    hold(1'b0, 562);
                    hold(1'b1, 400);
                    return;
                end
                hold(1'b1, c[i] ? jit(1687, 150, j) : jit(562, 100, j));
            end
            hold(1'b0, jit(562, 100, j));
            hold(1'b1, 400);
        end
    endtask

    task automatic apply(input string nm, input logic [31:0] c, input bit rpt, input int bad_bit,
                         input bit j, input bit exp_v, input bit exp_e,
                         input logic [31:0] exp_code, input bit exp_r);
        int v0;
        int e0;
        v0 = n_valid;
        e0 = n_err;
        send_frame(c, rpt, bad_bit, j);
        if (exp_v) m_tog = ~m_tog;
        m_code = exp_code;
        m_rpt  = exp_r;
        chk({nm, ".valid"},  32'(n_valid - v0), 32'(exp_v));
        chk({nm, ".err"},    32'(n_err - e0),   32'(exp_e));
        chk({nm, ".code"},   bif.code,          m_code);
        chk({nm, ".rpt"},    32'(bif.is_repeat), 32'(m_rpt));
        chk({nm, ".toggle"}, 32'(bif.frame_toggle), 32'(m_tog));
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, ".code"},   bif.code, 32'h0);
        chk({nm, ".valid"},  32'(bif.code_valid), 32'h0);
        chk({nm, ".rpt"},    32'(bif.is_repeat), 32'h0);
        chk({nm, ".toggle"}, 32'(bif.frame_toggle), 32'h0);
        chk({nm, ".err"},    32'(bif.frame_err), 32'h0);
    endtask

    initial begin
        int lat;
        int v0;
        int e0;
        logic [31:0] c;
        logic [7:0]  a8;
        logic [7:0]  c8;
        bit          rpt;
        int          bb;
        bit          ev;

        tbl[0] = '{32'hBA45FF00, 1'b0, -1, 1'b1, 1'b0, 32'hBA45FF00, 1'b0};
        tbl[1] = '{32'h00000000, 1'b1, -1, 1'b1, 1'b0, 32'hBA45FF00, 1'b1};
        tbl[2] = '{32'hED12CC33, 1'b0, 17, 1'b0, 1'b1, 32'hBA45FF00, 1'b1};
        tbl[3] = '{32'hED12CC33, 1'b0, -1, 1'b1, 1'b0, 32'hED12CC33, 1'b0};
`ifdef IR_NEC_CHECK_EN
        tbl[4] = '{32'hBB45FF00, 1'b0, -1, 1'b0, 1'b1, 32'hED12CC33, 1'b0};
`else
        tbl[4] = '{32'hBB45FF00, 1'b0, -1, 1'b1, 1'b0, 32'hBB45FF00, 1'b0};
`endif

        bif.ir_rx = 1'b1;
        reset_n   = 1'b0;
        m_code = '0;
        m_rpt  = 1'b0;
        m_tog  = 1'b0;
        repeat (4) @(negedge clk);
        chk_zero("reset");
        reset_n = 1'b1;
        hold(1'b1, 400);

        for (int i = 0; i < 5; i++)
            apply($sformatf("vec%0d", i), tbl[i].code, tbl[i].rpt, tbl[i].bad_bit, 1'b0,
                  tbl[i].exp_v, tbl[i].exp_e, tbl[i].exp_code, tbl[i].exp_r);

        // Line stuck low: the abort must land near 12000 us (750 ticks) after the fall.
        v0 = n_valid;
        e0 = n_err;
        bif.ir_rx = 1'b0;
        lat = 0;
        while (lat < 1200) begin
            @(negedge clk);
            lat++;
            if (bif.frame_err) break;
        end
        chk("timeout.lat", 32'(lat >= 745 && lat <= 765), 32'h1);
        if (lat < 937) repeat (937 - lat) @(negedge clk);
        hold(1'b1, 800);
        chk("timeout.err",    32'(n_err - e0),   32'h1);
        chk("timeout.valid",  32'(n_valid - v0), 32'h0);
        chk("timeout.code",   bif.code, m_code);
        chk("timeout.rpt",    32'(bif.is_repeat), 32'(m_rpt));
        chk("timeout.toggle", 32'(bif.frame_toggle), 32'(m_tog));

        for (int k = 0; k < 6; k++) begin
            a8  = 8'($urandom);
            c8  = 8'($urandom);
            c   = {~c8, c8, 8'($urandom), a8};
            if ($urandom_range(3) == 0) c[31:24] = c[31:24] ^ 8'h10;
            rpt = ($urandom_range(4) == 0);
            bb  = ($urandom_range(3) == 0) ? int'($urandom_range(31)) : -1;
            if (rpt)          ev = 1'b1;
            else if (bb >= 0) ev = 1'b0;
            else              ev = cmd_ok(c);
            apply($sformatf("rnd%0d", k), c, rpt, rpt ? -1 : bb, 1'b1, ev, ~ev,
                  (ev && !rpt) ? c : m_code, ev ? rpt : m_rpt);
        end

        // Reset in the middle of a frame, then a clean frame.
        hold(1'b0, 9000);
        hold(1'b1, 4500);
        for (int i = 0; i < 20; i++) begin
            hold(1'b0, 562);
            hold(1'b1, (i % 3 == 0) ? 1687 : 562);
        end
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_zero("midreset");
        m_code = '0;
        m_rpt  = 1'b0;
        m_tog  = 1'b0;
        reset_n = 1'b1;
        hold(1'b1, 400);
        apply("after_reset", 32'hBA45FF00, 1'b0, -1, 1'b0, 1'b1, 1'b0, 32'hBA45FF00, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
